// File: rtl/trade_pkg.sv
// Types and widths shared by the strategy, preprocessor and order-management blocks.
package trade_pkg;
    localparam int PRICE_W = 8;
    localparam int POS_W   = 8;
    localparam int QTY_W   = 4;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } om_state_t;

    typedef struct packed {
        side_t              side;
        logic [PRICE_W-1:0] price;
    } order_t;
endpackage

// File: rtl/trade_order_manager_if.sv
// Order handshake toward the order-entry/TX stage.
interface trade_order_manager_if;
    import trade_pkg::*;

    logic               order_valid;
    logic               order_ready;
    side_t              order_side;
    logic [PRICE_W-1:0] order_price;
    logic [QTY_W-1:0]   order_qty;

    modport master (
        output order_valid, order_side, order_price, order_qty,
        input  order_ready
    );

    modport slave (
        input  order_valid, order_side, order_price, order_qty,
        output order_ready
    );
endinterface

// File: rtl/trade_cooldown_timer.sv
// Loadable down-counter; done flags the last cooldown cycle (count == 1).
module trade_cooldown_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done,
    output logic         active
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done   = (cnt_q == W'(1));
    assign active = (cnt_q != '0);
endmodule

// File: rtl/trade_order_manager.sv
// Turns strategy buy/sell pulses into single handshaken orders, with a position
// limit, a post-order cooldown and saturating debug counters.
module trade_order_manager
    import trade_pkg::*;
#(
    parameter int MAX_POS         = 8,
    parameter int ORDER_QTY       = 1,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     buy_signal,
    input  logic                     sell_signal,
    input  logic [PRICE_W-1:0]       current_price,
    trade_order_manager_if.master    ord,
    output logic signed [POS_W-1:0]  position,
    output logic [CNT_W-1:0]         orders_sent,
    output logic [CNT_W-1:0]         signals_rejected,
    output logic                     busy
);
    localparam int CD_W = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
    localparam logic signed [POS_W:0]   QTY_S = (POS_W+1)'(ORDER_QTY);
    localparam logic signed [POS_W:0]   MAX_S = (POS_W+1)'(MAX_POS);
    localparam logic signed [POS_W-1:0] QTY_P = POS_W'(ORDER_QTY);

    om_state_t               state_q, state_d;
    order_t                  ord_q, ord_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0]        sent_q, sent_d, rej_q, rej_d;

    logic signed [POS_W:0]   pos_ext;
    logic buy_ok, sell_ok, one_sig, accept, hs;
    logic cd_load, cd_done, cd_active;

    // One bit of headroom so position +/- qty never wraps before the compare.
    assign pos_ext = {pos_q[POS_W-1], pos_q};
    assign buy_ok  = (pos_ext + QTY_S) <= MAX_S;
    assign sell_ok = (pos_ext - QTY_S) >= -MAX_S;
    assign one_sig = buy_signal ^ sell_signal;
    assign accept  = one_sig && (sell_signal ? sell_ok : buy_ok);
    assign hs      = (state_q == ISSUE) && ord.order_ready;

    trade_cooldown_timer #(.W(CD_W)) u_cooldown (
        .clk        (clk),
        .rst        (rst),
        .load       (cd_load),
        .load_value (CD_W'(COOLDOWN_CYCLES)),
        .done       (cd_done),
        .active     (cd_active)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cd_load = 1'b0;
        case (state_q)
            IDLE:
                if (accept) state_d = ISSUE;
            ISSUE:
                if (hs) begin
                    if (COOLDOWN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = COOLDOWN;
                        cd_load = 1'b1;
                    end
                end
            COOLDOWN:
                if (cd_done || !cd_active) state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_comb begin
        ord.order_valid = (state_q == ISSUE);
        ord.order_side  = ord_q.side;
        ord.order_price = ord_q.price;
        ord.order_qty   = QTY_W'(ORDER_QTY);
        busy            = (state_q != IDLE);
    end

    // Signals outside IDLE are dropped outright: not latched, not counted.
    always_comb begin
        ord_d  = ord_q;
        pos_d  = pos_q;
        sent_d = sent_q;
        rej_d  = rej_q;
        if (state_q == IDLE) begin
            if (accept) begin
                ord_d.side  = sell_signal ? SIDE_SELL : SIDE_BUY;
                ord_d.price = current_price;
            end else if (buy_signal || sell_signal) begin
                rej_d = (&rej_q) ? rej_q : rej_q + CNT_W'(1);
            end
        end
        if (hs) begin
            pos_d  = (ord_q.side == SIDE_SELL) ? pos_q - QTY_P : pos_q + QTY_P;
            sent_d = (&sent_q) ? sent_q : sent_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ord_q  <= '{side: SIDE_BUY, price: '0};
            pos_q  <= '0;
            sent_q <= '0;
            rej_q  <= '0;
        end else begin
            ord_q  <= ord_d;
            pos_q  <= pos_d;
            sent_q <= sent_d;
            rej_q  <= rej_d;
        end
    end

    assign position         = pos_q;
    assign orders_sent      = sent_q;
    assign signals_rejected = rej_q;
endmodule

// File: tb/tb_trade_order_manager.sv
// Scoreboard bench: three configurations (default, tight limit with narrow
// counters, zero cooldown) share one clock and reset.
module tb_trade_order_manager;
    import trade_pkg::*;

    logic clk, rst;
    int   nchk, nfail;

    logic a_buy, a_sell, b_buy, b_sell, c_buy, c_sell;
    logic [7:0] a_price, b_price, c_price;
    logic [7:0] a_pos, b_pos, c_pos;
    logic [15:0] a_sent, a_rej, c_sent, c_rej;
    logic [2:0]  b_sent, b_rej;
    logic a_busy, b_busy, c_busy;

    trade_order_manager_if a_if();
    trade_order_manager_if b_if();
    trade_order_manager_if c_if();

    trade_order_manager u_a (
        .clk(clk), .rst(rst), .buy_signal(a_buy), .sell_signal(a_sell),
        .current_price(a_price), .ord(a_if), .position(a_pos),
        .orders_sent(a_sent), .signals_rejected(a_rej), .busy(a_busy));

    trade_order_manager #(.MAX_POS(2), .COOLDOWN_CYCLES(2), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .buy_signal(b_buy), .sell_signal(b_sell),
        .current_price(b_price), .ord(b_if), .position(b_pos),
        .orders_sent(b_sent), .signals_rejected(b_rej), .busy(b_busy));

    trade_order_manager #(.COOLDOWN_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .buy_signal(c_buy), .sell_signal(c_sell),
        .current_price(c_price), .ord(c_if), .position(c_pos),
        .orders_sent(c_sent), .signals_rejected(c_rej), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    order_t qa[$], qb[$], qc[$];
    bit     hold [3];
    order_t prv  [3];
    int     vcnt [3];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Fields must hold while stalled; each handshake pops one expected order.
    task automatic mon(input int d, input logic v, input logic r, input logic s,
                       input logic [7:0] p, input logic [3:0] q);
        order_t e;
        bit got;
        if (!v) begin
            hold[d] = 0;
            return;
        end
        vcnt[d]++;
        if (hold[d]) begin
            chk($sformatf("stable_side_%0d", d), int'(s), int'(prv[d].side));
            chk($sformatf("stable_price_%0d", d), int'(p), int'(prv[d].price));
        end
        if (r) begin
            got = 0;
            case (d)
                0: if (qa.size() > 0) begin e = qa.pop_front(); got = 1; end
                1: if (qb.size() > 0) begin e = qb.pop_front(); got = 1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1; end
            endcase
            chk($sformatf("order_expected_%0d", d), int'(got), 1);
            if (got) begin
                chk($sformatf("order_side_%0d", d), int'(s), int'(e.side));
                chk($sformatf("order_price_%0d", d), int'(p), int'(e.price));
                chk($sformatf("order_qty_%0d", d), int'(q), 1);
            end
            hold[d] = 0;
        end else begin
            hold[d]       = 1;
            prv[d].side   = side_t'(s);
            prv[d].price  = p;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = 0; hold[1] = 0; hold[2] = 0;
        end else begin
            mon(0, a_if.order_valid, a_if.order_ready, a_if.order_side, a_if.order_price, a_if.order_qty);
            mon(1, b_if.order_valid, b_if.order_ready, b_if.order_side, b_if.order_price, b_if.order_qty);
            mon(2, c_if.order_valid, c_if.order_ready, c_if.order_side, c_if.order_price, c_if.order_qty);
        end
    end

    task automatic wait_idle_a();
        int i;
        i = 0;
        while (a_busy && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("a_idle_timeout", int'(a_busy), 0);
    endtask

    initial begin
        int n;
        nchk = 0; nfail = 0;
        rst = 1'b1;
        a_buy = 0; a_sell = 0; a_price = 0;
        b_buy = 0; b_sell = 0; b_price = 0;
        c_buy = 0; c_sell = 0; c_price = 0;
        a_if.order_ready = 1'b0;
        b_if.order_ready = 1'b1;
        c_if.order_ready = 1'b1;

        @(negedge clk);
        chk("rst_valid", int'(a_if.order_valid), 0);
        chk("rst_side",  int'(a_if.order_side), 0);
        chk("rst_price", int'(a_if.order_price), 0);
        chk("rst_qty",   int'(a_if.order_qty), 1);
        chk("rst_pos",   int'(a_pos), 0);
        chk("rst_sent",  int'(a_sent), 0);
        chk("rst_rej",   int'(a_rej), 0);
        chk("rst_busy",  int'(a_busy), 0);
        @(posedge clk); #2 rst = 1'b0;

        // B: buy held against MAX_POS=2; rejections saturate a 3-bit counter.
        @(posedge clk); #2 b_buy = 1; b_price = 8'd10;
        repeat (2) qb.push_back('{SIDE_BUY, 8'd10});
        repeat (20) @(posedge clk);
        #2 b_buy = 0;
        @(negedge clk);
        chk("b_pos_limit",  int'($signed(b_pos)), 2);
        chk("b_sent_limit", int'(b_sent), 2);
        chk("b_rej_sat",    int'(b_rej), 7);

        @(posedge clk); #2 b_sell = 1; b_price = 8'd200;
        repeat (4) qb.push_back('{SIDE_SELL, 8'd200});
        repeat (30) @(posedge clk);
        #2 b_sell = 0;
        @(negedge clk);
        chk("b_pos_neg_limit", int'($signed(b_pos)), -2);
        chk("b_sent_total",    int'(b_sent), 6);
        chk("b_rej_held",      int'(b_rej), 7);

        // C: zero cooldown gives an order every second cycle.
        @(posedge clk); #2 c_buy = 1; c_price = 8'd55;
        repeat (4) qc.push_back('{SIDE_BUY, 8'd55});
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            if (i == 8) #2 c_buy = 0;
            @(negedge clk);
            chk($sformatf("c_valid_cyc%0d", i), int'(c_if.order_valid), i % 2);
        end
        chk("c_sent", int'(c_sent), 4);
        chk("c_pos",  int'($signed(c_pos)), 4);
        chk("c_busy", int'(c_busy), 0);

        // A: single buy pulse, ready high, 8-cycle cooldown.
        @(posedge clk); #2 a_buy = 1; a_price = 8'd42; a_if.order_ready = 1;
        qa.push_back('{SIDE_BUY, 8'd42});
        @(posedge clk); #2 a_buy = 0;
        @(negedge clk);
        chk("a_latency_valid", int'(a_if.order_valid), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            if (!a_if.order_valid) n++;
        end
        chk("a_cooldown_len", n, 8);
        chk("a_pos_buy",  int'($signed(a_pos)), 1);
        chk("a_sent_buy", int'(a_sent), 1);
        chk("a_rej_buy",  int'(a_rej), 0);

        // A: sell held while stalled 5 cycles; held through part of cooldown.
        @(posedge clk); #2 a_sell = 1; a_price = 8'd77; a_if.order_ready = 0;
        qa.push_back('{SIDE_SELL, 8'd77});
        vcnt[0] = 0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 a_if.order_ready = 1;
        repeat (5) @(posedge clk);
        #2 a_sell = 0;
        wait_idle_a();
        chk("a_valid_cycles", vcnt[0], 6);
        chk("a_pos_sell",  int'($signed(a_pos)), 0);
        chk("a_sent_sell", int'(a_sent), 2);
        chk("a_rej_sell",  int'(a_rej), 0);

        // A: conflicting signals for three IDLE cycles.
        @(posedge clk); #2 a_buy = 1; a_sell = 1; vcnt[0] = 0;
        repeat (3) @(posedge clk);
        #2 a_buy = 0; a_sell = 0;
        @(negedge clk);
        chk("a_conflict_rej",   int'(a_rej), 3);
        chk("a_conflict_valid", vcnt[0], 0);
        chk("a_conflict_busy",  int'(a_busy), 0);

        @(posedge clk); #2 a_buy = 1; a_price = 8'd13;
        qa.push_back('{SIDE_BUY, 8'd13});
        @(posedge clk); #2 a_buy = 0;
        wait_idle_a();
        chk("a_pos_buy2",  int'($signed(a_pos)), 1);
        chk("a_sent_buy2", int'(a_sent), 3);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        // A: reset during a stalled order clears everything without a clock edge.
        @(posedge clk); #2 a_buy = 1; a_price = 8'd99; a_if.order_ready = 0;
        qa.push_back('{SIDE_BUY, 8'd99});
        @(posedge clk); #2 a_buy = 0;
        @(negedge clk);
        chk("a_pre_rst_valid", int'(a_if.order_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("a_async_valid", int'(a_if.order_valid), 0);
        chk("a_async_pos",   int'($signed(a_pos)), 0);
        chk("a_async_sent",  int'(a_sent), 0);
        chk("a_async_rej",   int'(a_rej), 0);
        chk("a_async_busy",  int'(a_busy), 0);
        qa.delete();
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("a_post_rst_valid", int'(a_if.order_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
